wb_bus_arbiter: RTL and testbench
=================================

WB_BUS_ARBITER -- requirements
Module: wb_bus_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 4: number of WISHBONE masters sharing the bus, legal range 2..16.
REQ-002 SHALL have parameter N_BITS_MASTER_ID, default 2: width of the owner index; 2**N_BITS_MASTER_ID >= N_MASTERS.
REQ-003 SHALL have parameter N_BITS_TIMEOUT, default 8: width of the watchdog counter.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 200: number of GRANT cycles without bus termination that triggers a watchdog release; must be < 2**N_BITS_TIMEOUT.
REQ-005 clk  input  1  clock; all logic on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 cyc_i  input  N_MASTERS  CYC_O of each master; bit i high means master i requests or holds the bus.
REQ-008 ack_i  input  1  ACK from the shared slave side.
REQ-009 err_i  input  1  ERR from the shared slave side.
REQ-010 rty_i  input  1  RTY from the shared slave side.
REQ-011 gnt_o  output  N_MASTERS  one-hot grant, registered; drives each master's gnt_wb_i.
REQ-012 gnt_id_o  output  N_BITS_MASTER_ID  index of the current owner, valid while bus_busy_o is high.
REQ-013 bus_busy_o  output  1  high while any grant is active.
REQ-014 timeout_o  output  1  one-cycle pulse on a watchdog release.

Function
REQ-015 SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one owner).
REQ-016 In IDLE, if cyc_i != 0, SHALL select the winner by round-robin: search indices last_owner+1, last_owner+2, ... modulo N_MASTERS; the first index with its cyc_i bit high wins.
REQ-017 In IDLE with a winner, SHALL go to GRANT and register gnt_o = one-hot(winner), gnt_id_o = winner, bus_busy_o = 1 on the next edge; grant latency is exactly 1 cycle after cyc_i rises.
REQ-018 In IDLE with cyc_i == 0, SHALL stay in IDLE with gnt_o = 0.
REQ-019 In GRANT, SHALL hold the grant while cyc_i[gnt_id_o] is high, regardless of any other cyc_i bits.
REQ-020 In GRANT, when cyc_i[gnt_id_o] is low, SHALL go to IDLE and clear gnt_o and bus_busy_o on the next edge.
REQ-021 Releasing a grant SHALL always pass through at least one IDLE cycle with gnt_o = 0 (bus turnaround) before any new grant.
REQ-022 last_owner SHALL update to the winner on each grant; gnt_id_o SHALL hold its last value while in IDLE.
REQ-023 Cyc_i bits for indices >= N_MASTERS do not exist; the round-robin search SHALL wrap from N_MASTERS-1 to 0.
REQ-024 gnt_o SHALL never have more than one bit set.
REQ-025 Changes on non-owner cyc_i bits during GRANT SHALL have no effect until the next IDLE arbitration.

Reset
REQ-026 On rst, SHALL set state = IDLE, gnt_o = 0, gnt_id_o = 0, bus_busy_o = 0, timeout_o = 0, watchdog counter = 0, and last_owner = N_MASTERS-1, so that master 0 wins the first arbitration.
REQ-027 rst asserted during GRANT SHALL drop the grant on the next edge, independent of cyc_i.

Configuration
REQ-028 Macro WB_ARB_TIMEOUT_EN defined: the watchdog counter SHALL clear on entry to GRANT and on any ack_i, err_i or rty_i; it SHALL increment once per GRANT cycle otherwise.
REQ-029 When the watchdog counter reaches TIMEOUT_CYCLES-1 in a cycle with no termination, SHALL go to IDLE, clear gnt_o, and pulse timeout_o for one cycle; gnt_id_o SHALL keep the timed-out owner during that cycle.
REQ-030 A timed-out master still holding cyc SHALL be re-arbitrated as lowest priority under round-robin.
REQ-031 Macro WB_ARB_TIMEOUT_EN undefined: SHALL contain no counter, tie timeout_o to 0, and hold the grant indefinitely per REQ-019.
REQ-032 Simultaneous owner cyc drop and timeout SHALL release once, with timeout_o = 0 (the cyc drop takes priority).

Verification
REQ-033 After reset, cyc_i=4'b1010 at cycle 0 -> gnt_o=4'b0010, gnt_id_o=1 at cycle 1; other bits ignored until master 1 drops cyc.
REQ-034 All cyc_i=4'b1111 continuously, each owner holding 3 cycles -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-035 Owner 3 drops cyc while cyc_i[0] is high -> one IDLE cycle, then gnt_o=4'b0001 (wrap-around).
REQ-036 With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=10, master 2 holds cyc with no ack -> timeout_o pulses in the 10th GRANT cycle, then gnt_o=0; an ack every 5 cycles -> no timeout.
REQ-037 rst asserted mid-GRANT with cyc_i=4'b0100 -> gnt_o=0 on the next edge; after rst drops, master 2 is re-granted 1 cycle later.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Round-robin WISHBONE bus arbiter with one-cycle turnaround between grants.
// Optional watchdog release of a stalled owner is built when WB_ARB_TIMEOUT_EN is defined.
module wb_bus_arbiter #(
  parameter int N_MASTERS        = 4,
  parameter int N_BITS_MASTER_ID = 2,
  parameter int N_BITS_TIMEOUT   = 8,
  parameter int TIMEOUT_CYCLES   = 200
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_MASTERS-1:0]        cyc_i,
  input  logic                        ack_i,
  input  logic                        err_i,
  input  logic                        rty_i,
  output logic [N_MASTERS-1:0]        gnt_o,
  output logic [N_BITS_MASTER_ID-1:0] gnt_id_o,
  output logic                        bus_busy_o,
  output logic                        timeout_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [N_BITS_MASTER_ID-1:0] LAST_INIT = N_BITS_MASTER_ID'(N_MASTERS - 1);
  localparam logic [N_MASTERS-1:0]        ONE_HOT0  = N_MASTERS'(1);

  state_t                      state_reg;
  logic [N_MASTERS-1:0]        gnt_reg;
  logic [N_BITS_MASTER_ID-1:0] gnt_id_reg;
  logic [N_BITS_MASTER_ID-1:0] last_owner_reg;
  logic                        busy_reg;
  logic                        timeout_reg;
  logic [N_BITS_MASTER_ID-1:0] winner;
  logic                        found;
  logic                        owner_cyc;
  logic                        wdog_expire;

  // Search starts just after the previous owner so it becomes lowest priority.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      idx = int'(last_owner_reg) + k;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
      if (!found && cyc_i[idx]) begin
        found  = 1'b1;
        winner = N_BITS_MASTER_ID'(idx);
      end
    end
  end

  assign owner_cyc = cyc_i[gnt_id_reg];

`ifdef WB_ARB_TIMEOUT_EN
  logic [N_BITS_TIMEOUT-1:0] wdog_reg;
  logic                      term;

  assign term        = ack_i | err_i | rty_i;
  assign wdog_expire = !term && (wdog_reg == N_BITS_TIMEOUT'(TIMEOUT_CYCLES - 1));

  // Held at zero while idle, so every new grant starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst || state_reg == IDLE || term || wdog_expire) begin
      wdog_reg <= '0;
    end else begin
      wdog_reg <= wdog_reg + N_BITS_TIMEOUT'(1);
    end
  end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES + N_BITS_TIMEOUT;
  logic unused_term;
  assign unused_term = ack_i ^ err_i ^ rty_i;
  assign wdog_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      gnt_reg        <= '0;
      gnt_id_reg     <= '0;
      busy_reg       <= 1'b0;
      timeout_reg    <= 1'b0;
      last_owner_reg <= LAST_INIT;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (found) begin
            state_reg      <= GRANT;
            gnt_reg        <= ONE_HOT0 << winner;
            gnt_id_reg     <= winner;
            last_owner_reg <= winner;
            busy_reg       <= 1'b1;
          end
        end
        GRANT: begin
          // An owner dropping cyc wins over a coincident watchdog expiry.
          if (!owner_cyc || wdog_expire) begin
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            busy_reg    <= 1'b0;
            timeout_reg <= owner_cyc;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt_o      = gnt_reg;
  assign gnt_id_o   = gnt_id_reg;
  assign bus_busy_o = busy_reg;
  assign timeout_o  = timeout_reg;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Randomized and directed bench for wb_bus_arbiter against a behavioural arbitration model.
module tb_wb_bus_arbiter;
  localparam int N  = 4;
  localparam int TO = 10;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cyc = '0;
  logic       ack = 1'b0, err = 1'b0, rty = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy, tout;

  wb_bus_arbiter #(
    .N_MASTERS(N), .N_BITS_MASTER_ID(2), .N_BITS_TIMEOUT(8), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .cyc_i(cyc), .ack_i(ack), .err_i(err), .rty_i(rty),
    .gnt_o(gnt), .gnt_id_o(gnt_id), .bus_busy_o(busy), .timeout_o(tout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  // Model: who owns the bus, who owned it last, and how many grant cycles since a termination.
  bit m_busy, m_to;
  int m_owner, m_last, m_streak;
  int grant_order[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cycle, got, exp);
    end
  endtask

  task automatic model_step(logic [3:0] c, bit term, bit r);
    if (r) begin
      m_busy = 0; m_owner = 0; m_last = N - 1; m_streak = 0; m_to = 0;
      return;
    end
    m_to = 0;
    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (c[i]) begin
          m_owner = i; m_last = i; m_busy = 1; m_streak = 0;
          break;
        end
      end
    end else if (!c[m_owner]) begin
      m_busy = 0;
    end else if (TO_EN) begin
      if (term) m_streak = 0;
      else begin
        m_streak++;
        if (m_streak == TO) begin
          m_busy = 0; m_to = 1;
        end
      end
    end
  endtask

  task automatic step(logic [3:0] c, bit a, bit e, bit ry, bit r);
    bit prev;
    logic [3:0] one;
    logic [3:0] exp_gnt;
    cyc = c; ack = a; err = e; rty = ry; rst = r;
    @(posedge clk);
    prev = m_busy;
    model_step(c, a | e | ry, r);
    cycle++;
    #1;
    one = 4'b0001;
    exp_gnt = m_busy ? (one << m_owner) : 4'b0000;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("gnt_id", 32'(gnt_id), 32'(m_owner));
    check("busy", 32'(busy), 32'(m_busy));
    check("timeout", 32'(tout), 32'(m_to));
    if (!prev && m_busy) begin
      grant_order.push_back(m_owner);
      $display("cycle %0d: grant to master %0d", cycle, m_owner);
    end
  endtask

  initial begin
    int held, high_cnt;
    bit to_seen;
    logic [3:0] c;

    // Reset state
    step(4'b0000, 0, 0, 0, 1);
    step(4'b0000, 0, 0, 0, 1);
    check("reset_gnt", 32'(gnt), 32'h0);

    // First arbitration after reset, other requests ignored while master 1 holds
    step(4'b1010, 0, 0, 0, 0);
    check("first_gnt", 32'(gnt), 32'h2);
    check("first_id", 32'(gnt_id), 32'h1);
    step(4'b1011, 0, 0, 0, 0);
    step(4'b1111, 0, 0, 0, 0);
    check("hold_gnt", 32'(gnt), 32'h2);
    step(4'b1101, 0, 0, 0, 0);
    check("turnaround", 32'(gnt), 32'h0);
    step(4'b1101, 0, 0, 0, 0);
    check("next_owner", 32'(gnt), 32'h4);

    // All request, each owner holds 3 cycles
    step(4'b0000, 0, 0, 0, 1);
    grant_order.delete();
    held = 0;
    for (int t = 0; t < 20; t++) begin
      c = 4'b1111;
      if (m_busy && held == 3) c[m_owner] = 1'b0;
      step(c, 0, 0, 0, 0);
      held = m_busy ? held + 1 : 0;
    end
    check("order_len", 32'(grant_order.size()), 32'd5);
    for (int i = 0; i < 5 && i < grant_order.size(); i++)
      check("order", 32'(grant_order[i]), 32'(i % 4));

    // Wrap-around from master 3 to master 0
    step(4'b0000, 0, 0, 0, 1);
    step(4'b1000, 0, 0, 0, 0);
    check("own3", 32'(gnt), 32'h8);
    step(4'b1001, 0, 0, 0, 0);
    step(4'b0001, 0, 0, 0, 0);
    check("wrap_idle", 32'(gnt), 32'h0);
    step(4'b0001, 0, 0, 0, 0);
    check("wrap_gnt", 32'(gnt), 32'h1);

    // Stalled owner: watchdog release when enabled, indefinite hold otherwise
    step(4'b0000, 0, 0, 0, 1);
    high_cnt = 0;
    for (int t = 0; t < 11; t++) begin
      step(4'b0100, 0, 0, 0, 0);
      if (gnt == 4'b0100) high_cnt++;
    end
    check("stall_cycles", 32'(high_cnt), TO_EN ? 32'd10 : 32'd11);
    check("stall_timeout", 32'(tout), 32'(TO_EN));
    check("stall_id", 32'(gnt_id), 32'd2);

    // Periodic ack keeps the watchdog quiet
    step(4'b0000, 0, 0, 0, 1);
    to_seen = 0;
    for (int t = 0; t < 30; t++) begin
      step(4'b0100, (t % 5) == 4, 0, 0, 0);
      if (tout) to_seen = 1;
    end
    check("ack_no_timeout", 32'(to_seen), 32'd0);
    check("ack_hold", 32'(gnt), 32'h4);

    // Reset during grant, then re-grant
    step(4'b0100, 0, 0, 0, 1);
    step(4'b0100, 0, 0, 0, 0);
    step(4'b0100, 0, 0, 0, 0);
    step(4'b0100, 0, 0, 0, 1);
    check("rst_drop", 32'(gnt), 32'h0);
    step(4'b0100, 0, 0, 0, 0);
    check("rst_regrant", 32'(gnt), 32'h4);

    // Random traffic with sticky requests
    c = 4'b0000;
    for (int t = 0; t < 3000; t++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(5) == 0) c[b] = ~c[b];
      step(c, $urandom_range(7) == 0, $urandom_range(31) == 0,
           $urandom_range(31) == 0, $urandom_range(199) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
